aes_128_keyram_writer: RTL and testbench

Write-side sequencer for the AES-128 round-key RAM (64-bit wide, 22 entries: 11 round keys × 2 halves). Accepts 128-bit round keys one at a time from the key-expansion core over a valid/ready handshake. Splits each key into two 64-bit RAM writes and drives en_wr so the key RAM read controller yields the address bus during loading. Signals completion with a one-cycle key_ready pulse.

---
 rtl/aes_128_keyram_writer.sv | 119 +++++++++++
 tb/tb_aes_128_keyram_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_keyram_writer.sv
// AES-128 round-key RAM write sequencer: splits 128-bit round keys into two 64-bit writes.
// Optional build macro KEYRAM_RESTART_EN: key_start while loading restarts the set from key 0.
module aes_128_keyram_writer #(
    parameter int NUM_RK = 11,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              key_start,
    input  logic              rk_valid,
    input  logic [127:0]      rk_data,
    output logic              rk_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [63:0]       ram_din,
    output logic              en_wr,
    output logic              key_ready,
    output logic              busy
);

    // Two RAM entries per key, so the key index is one bit narrower than the address.
    localparam int IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RK - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RK,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rk_idx, idx_nxt;
    logic [127:0]       rk_hold, hold_nxt;
    logic               restart;

`ifdef KEYRAM_RESTART_EN
    assign restart = key_start && (state == WAIT_RK || state == WR_LO || state == WR_HI);
`else
    assign restart = 1'b0;
`endif

    assign rk_ready  = (state == WAIT_RK);
    assign en_wr     = (state == WAIT_RK) || (state == WR_LO) || (state == WR_HI);
    assign key_ready = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        idx_nxt   = rk_idx;
        hold_nxt  = rk_hold;
        case (state)
            IDLE: begin
                if (key_start) begin
                    state_nxt = WAIT_RK;
                    idx_nxt   = '0;
                end
            end
            WAIT_RK: begin
                if (rk_valid) begin
                    hold_nxt  = rk_data;
                    state_nxt = WR_LO;
                end
            end
            WR_LO: state_nxt = WR_HI;
            WR_HI: begin
                if (rk_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = rk_idx + IDX_W'(1);
                    state_nxt = WAIT_RK;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A restart drops any capture this cycle and rewinds to the cipher key.
        if (restart) begin
            state_nxt = WAIT_RK;
            idx_nxt   = '0;
            hold_nxt  = rk_hold;
        end
    end

    // Write port is registered from the next state, so it lines up with WR_LO/WR_HI.
    always_ff @(posedge clk) begin
        if (kill) begin
            state    <= IDLE;
            rk_idx   <= '0;
            rk_hold  <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            state   <= state_nxt;
            rk_idx  <= idx_nxt;
            rk_hold <= hold_nxt;
            case (state_nxt)
                WR_LO: begin
                    ram_we   <= 1'b1;
                    ram_addr <= {idx_nxt, 1'b0};
                    ram_din  <= hold_nxt[63:0];
                end
                WR_HI: begin
                    ram_we   <= 1'b1;
                    ram_addr <= {idx_nxt, 1'b1};
                    ram_din  <= hold_nxt[127:64];
                end
                default: begin
                    ram_we   <= 1'b0;
                    ram_addr <= '0;
                    ram_din  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_keyram_writer.sv
// Randomized bench for aes_128_keyram_writer with a key-list reference model and a stalling producer.
module tb_aes_128_keyram_writer;
    localparam int NUM_RK = 11;
    localparam int ADDR_W = 5;
`ifdef KEYRAM_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              kill = 1'b1;
    logic              key_start = 1'b0;
    logic              rk_valid = 1'b0;
    logic [127:0]      rk_data = '0;
    logic              rk_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_din;
    logic              en_wr;
    logic              key_ready;
    logic              busy;

    aes_128_keyram_writer #(.NUM_RK(NUM_RK), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .kill(kill), .key_start(key_start), .rk_valid(rk_valid), .rk_data(rk_data),
        .rk_ready(rk_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .en_wr(en_wr), .key_ready(key_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0]        keys [NUM_RK];
    logic [ADDR_W+63:0]  wr_q [$];
    int                  wr_cyc [$];
    int                  kr_cyc [$];
    logic [ADDR_W+63:0]  exp_q [$];
    int en_cnt = 0, inv_bad = 0;
    int load_id = 0, seen_id = 0, kp = 0, stall_cnt = 0, stall_n = 0;
    bit prod_en = 1'b0;
    int n_tests = 0, n_fail = 0;

    // Observer of the RAM port plus a producer that stalls stall_n ready cycles before each key.
    always @(negedge clk) begin
        if (ram_we) begin
            wr_q.push_back({ram_addr, ram_din});
            wr_cyc.push_back(cyc);
        end
        if (key_ready) kr_cyc.push_back(cyc);
        if (en_wr) en_cnt++;
        if (!ram_we && (ram_addr != '0 || ram_din != '0)) inv_bad++;
        if (en_wr != (busy && !key_ready)) inv_bad++;
        if (rk_ready && (!en_wr || ram_we)) inv_bad++;
        if (key_ready && !busy) inv_bad++;

        if (load_id != seen_id) begin
            seen_id   = load_id;
            kp        = 0;
            stall_cnt = 0;
        end
        if (!prod_en) begin
            rk_valid = 1'b0;
        end else begin
            rk_valid = (stall_cnt >= stall_n);
            rk_data  = (kp < NUM_RK) ? keys[kp] : '0;
            if (RESTART && key_start && busy && !key_ready) begin
                kp        = 0;
                stall_cnt = 0;
            end else if (rk_valid && rk_ready) begin
                kp++;
                stall_cnt = 0;
            end else if (rk_ready) begin
                stall_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_keys();
        for (int i = 0; i < NUM_RK; i++)
            keys[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Reference: key i lands as low half at 2i, high half at 2i+1, ascending.
    task automatic add_keys(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ADDR_W'(2 * i), keys[i][63:0]});
            exp_q.push_back({ADDR_W'(2 * i + 1), keys[i][127:64]});
        end
    endtask

    task automatic check_writes(input string tag, input int base);
        chk({tag, "_count"}, 128'(wr_q.size() - base), 128'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < wr_q.size())
                chk({tag, "_data"}, 128'(wr_q[base + k]), 128'(exp_q[k]));
    endtask

    task automatic wait_kr(input int n, input int budget);
        int t = 0;
        while (kr_cyc.size() < n && t < budget) begin
            step();
            t++;
        end
        chk("key_ready_timeout", 128'(kr_cyc.size() >= n), 128'(1));
    endtask

    task automatic wait_wr(input int n, input int budget);
        int t = 0;
        while (wr_q.size() < n && t < budget) begin
            step();
            t++;
        end
        chk("write_timeout", 128'(wr_q.size() >= n), 128'(1));
    endtask

    task automatic start_load(output int c0);
        load_id++;
        key_start = 1'b1;
        c0 = cyc;
        step();
        key_start = 1'b0;
    endtask

    initial begin
        int base, kb, e0, c0, c1, last;
        logic [ADDR_W+63:0] w;

        step();
        step();
        chk("reset_outputs",
            128'({rk_ready, ram_we, ram_addr, ram_din, en_wr, key_ready, busy}), 128'(0));
        kill    = 1'b0;
        prod_en = 1'b1;
        step();

        // Normal load with the producer always ready
        new_keys(); exp_q = {}; add_keys(NUM_RK);
        base = wr_q.size(); kb = kr_cyc.size(); e0 = en_cnt;
        start_load(c0);
        wait_kr(kb + 1, 200);
        repeat (3) step();
        check_writes("t1_wr", base);
        if (wr_q.size() >= base + 2 * NUM_RK)
            chk("t1_last_write_cycle", 128'(wr_cyc[base + 2 * NUM_RK - 1] - c0), 128'(33));
        if (kr_cyc.size() > kb)
            chk("t1_key_ready_cycle", 128'(kr_cyc[kb] - c0), 128'(34));
        chk("t1_key_ready_count", 128'(kr_cyc.size() - kb), 128'(1));
        chk("t1_en_wr_cycles", 128'(en_cnt - e0), 128'(33));

        // Stalled producer
        stall_n = 5;
        new_keys(); exp_q = {}; add_keys(NUM_RK);
        base = wr_q.size(); kb = kr_cyc.size();
        start_load(c0);
        wait_kr(kb + 1, 400);
        repeat (3) step();
        check_writes("t2_wr", base);
        if (kr_cyc.size() > kb && wr_q.size() >= base + 2 * NUM_RK) begin
            chk("t2_key_ready_cycle", 128'(kr_cyc[kb] - c0), 128'(34 + 5 * NUM_RK));
            chk("t2_key_ready_after_last", 128'(kr_cyc[kb] - wr_cyc[base + 2 * NUM_RK - 1]), 128'(1));
        end
        chk("t2_key_ready_count", 128'(kr_cyc.size() - kb), 128'(1));
        stall_n = 0;

        // kill during the high-half write of key 4
        new_keys();
        base = wr_q.size(); kb = kr_cyc.size();
        start_load(c0);
        wait_wr(base + 9, 100);
        kill = 1'b1;
        step();
        chk("t3_outputs_after_kill",
            128'({rk_ready, ram_we, ram_addr, ram_din, en_wr, key_ready, busy}), 128'(0));
        kill = 1'b0;
        chk("t3_write_count", 128'(wr_q.size() - base), 128'(10));
        w = wr_q[wr_q.size() - 1];
        chk("t3_last_addr", 128'(w[ADDR_W+63:64]), 128'(9));
        repeat (10) step();
        chk("t3_no_key_ready", 128'(kr_cyc.size() - kb), 128'(0));
        new_keys(); exp_q = {}; add_keys(NUM_RK);
        base = wr_q.size();
        start_load(c0);
        wait_kr(kb + 1, 200);
        repeat (3) step();
        check_writes("t3_reload", base);

        // key_start while loading key 6
        new_keys(); exp_q = {};
        if (RESTART) add_keys(6);
        add_keys(NUM_RK);
        base = wr_q.size(); kb = kr_cyc.size();
        start_load(c0);
        wait_wr(base + 12, 100);
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        wait_kr(kb + 1, 300);
        repeat (5) step();
        check_writes("t4_wr", base);
        chk("t4_key_ready_count", 128'(kr_cyc.size() - kb), 128'(1));

        // Idle noise: valid high without key_start
        base = wr_q.size();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_idle", 128'({rk_ready, ram_we, en_wr, busy}), 128'(0));
        end
        chk("t5_no_writes", 128'(wr_q.size() - base), 128'(0));

        // Back-to-back sets, second key_start in the cycle after DONE
        new_keys(); exp_q = {}; add_keys(NUM_RK);
        base = wr_q.size(); kb = kr_cyc.size();
        start_load(c0);
        wait_kr(kb + 1, 200);
        new_keys(); add_keys(NUM_RK);
        start_load(c1);
        wait_kr(kb + 2, 200);
        repeat (3) step();
        check_writes("t6_wr", base);
        chk("t6_key_ready_count", 128'(kr_cyc.size() - kb), 128'(2));
        if (kr_cyc.size() >= kb + 2) begin
            last = kr_cyc[kb + 1] - kr_cyc[kb];
            chk("t6_pulse_gap_ge_34", 128'(last >= 34), 128'(1));
        end

        chk("protocol_invariants", 128'(inv_bad), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
